// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkg
// Brief    : Shared width and keep-mask helpers for the stream upsizer.
// Revision : 1.0
// ============================================================================
package stream_pkg;

    // Upper bound on RATIO supported by the keep-mask helper.
    localparam int KEEP_MAX_W = 32;

    function automatic int upsizer_out_width(input int in_width, input int ratio);
        return in_width * ratio;
    endfunction

    function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int cnt, input int ratio);
        logic [KEEP_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            if (i < ratio && i <= cnt) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : stream_upsizer
// Brief    : Packs RATIO narrow beats into one registered wide word.
//            STREAM_UPSIZER_LAST_EN adds in_last/out_last/out_keep framing.
// Revision : 1.0
// ============================================================================
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    localparam int OUT_WIDTH = upsizer_out_width(IN_WIDTH, RATIO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef STREAM_UPSIZER_LAST_EN
    input  logic                 in_last,
    output logic                 out_last,
    output logic [RATIO-1:0]     out_keep,
`endif
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNT_W = $clog2(RATIO);
    localparam int ACC_W = IN_WIDTH * (RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    typedef struct packed {
        logic [CNT_W-1:0]     cnt;
        logic [ACC_W-1:0]     acc;
        logic [OUT_WIDTH-1:0] data;
        logic                 valid;
`ifdef STREAM_UPSIZER_LAST_EN
        logic                 last;
        logic [RATIO-1:0]     keep;
`endif
    } self_t;

    self_t                self_q;
    self_t                self_d;
    logic                 w_last_beat;
    logic                 w_beat_fire;
    logic                 w_word_fire;
    logic [OUT_WIDTH-1:0] w_word_full;
`ifdef STREAM_UPSIZER_LAST_EN
    logic [KEEP_MAX_W-1:0] w_keep_full;
    logic                  w_keep_unused;
    assign w_keep_unused = ^w_keep_full;
`endif

    always_comb begin
        w_last_beat = (self_q.cnt == CNT_LAST);
`ifdef STREAM_UPSIZER_LAST_EN
        w_last_beat = w_last_beat || in_last;
        w_keep_full = keep_mask(int'(self_q.cnt), RATIO);
`endif
        // Only the completing beat can be blocked, and only by a held word.
        in_ready    = !(w_last_beat && self_q.valid && !out_ready);
        w_beat_fire = in_valid && in_ready;
        w_word_fire = self_q.valid && out_ready;

        // Upper accumulation lanes are already zero, so early completion pads with 0.
        w_word_full = {{IN_WIDTH{1'b0}}, self_q.acc};
        w_word_full[int'(self_q.cnt)*IN_WIDTH +: IN_WIDTH] = in_data;

        self_d = self_q;
        if (w_word_fire) begin
            self_d.valid = 1'b0;
        end
        if (w_beat_fire && w_last_beat) begin
            self_d.data  = w_word_full;
            self_d.valid = 1'b1;
            self_d.acc   = '0;
            self_d.cnt   = '0;
`ifdef STREAM_UPSIZER_LAST_EN
            self_d.last  = in_last;
            self_d.keep  = w_keep_full[RATIO-1:0];
`endif
        end else if (w_beat_fire) begin
            self_d.acc[int'(self_q.cnt)*IN_WIDTH +: IN_WIDTH] = in_data;
            self_d.cnt = self_q.cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            self_q <= '0;
        end else begin
            self_q <= self_d;
        end
    end

    assign out_data  = self_q.data;
    assign out_valid = self_q.valid;
`ifdef STREAM_UPSIZER_LAST_EN
    assign out_last  = self_q.last;
    assign out_keep  = self_q.keep;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_upsizer
// Brief    : Directed and randomised scoreboard bench for stream_upsizer.
// Revision : 1.0
// ============================================================================
module tb_stream_upsizer;

    localparam int IN_WIDTH  = 8;
    localparam int RATIO     = 4;
    localparam int OUT_WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 tb_last;
`ifdef STREAM_UPSIZER_LAST_EN
    logic                 out_last;
    logic [RATIO-1:0]     out_keep;
`endif

    stream_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef STREAM_UPSIZER_LAST_EN
        .in_last   (tb_last),
        .out_last  (out_last),
        .out_keep  (out_keep),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          stalls   = 0;
    int          fifo_cnt = 0;
    bit          rand_mode = 1'b0;
    logic [31:0] exp_q[$];
    int          word_cyc[$];
    int          beat_cyc[$];
    logic [31:0] m_acc;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one beat starting just after a rising edge; returns just after the accepting edge.
    task automatic beat(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (!ok) check("beat_accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference packer and scoreboard, sampled mid-cycle.
    initial begin
        m_acc = '0;
        m_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_acc = '0;
                m_cnt = 0;
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    word_cyc.push_back(cyc);
                    if (rand_mode) fifo_cnt++;
                    if (exp_q.size() == 0) begin
                        check("sb_word_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check("sb_word", out_data, exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    beat_cyc.push_back(cyc);
                    m_acc[m_cnt*IN_WIDTH +: IN_WIDTH] = in_data;
                    m_cnt++;
                    if (m_cnt == RATIO || tb_last) begin
                        exp_q.push_back(m_acc);
                        m_acc = '0;
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    // Depth-4 fifo consumer: ready while it has room, drains randomly.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                if (fifo_cnt > 0 && $urandom_range(0, 1) == 1) fifo_cnt--;
                out_ready = (fifo_cnt < 4);
            end
        end
    end

    initial begin
        int n_words;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; tb_last = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic packing and one-cycle latency
        beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
        @(negedge clk);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data", out_data, 32'h44332211);
        @(negedge clk);
        check("basic_valid_drop", 32'(out_valid), 32'd0);

        // Continuous stream, no bubbles
        @(posedge clk); #1;
        word_cyc.delete(); beat_cyc.delete(); stalls = 0;
        for (int i = 0; i < 16; i++) beat(8'($urandom));
        repeat (3) @(negedge clk);
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_words", 32'(word_cyc.size()), 32'd4);
        if (word_cyc.size() == 4 && beat_cyc.size() > 0) begin
            check("stream_first_latency", 32'(word_cyc[0] - beat_cyc[0]), 32'd4);
            check("stream_spacing", 32'(word_cyc[3] - word_cyc[0]), 32'd12);
        end

        // Backpressure on the completing beat
        @(posedge clk); #1;
        out_ready = 1'b0; stalls = 0;
        beat(8'hA1); beat(8'hA2); beat(8'hA3); beat(8'hA4);
        beat(8'hA5); beat(8'hA6); beat(8'hA7);
        check("bp_no_stall_5_7", 32'(stalls), 32'd0);
        in_valid = 1'b1; in_data = 8'hA8;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_data_hold", out_data, 32'hA4A3A2A1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_reload_valid", 32'(out_valid), 32'd1);
        check("bp_reload_data", out_data, 32'hA8A7A6A5);
        @(negedge clk);
        check("bp_valid_drop", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-word with a held word
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(8'hB1); beat(8'hB2); beat(8'hB3); beat(8'hB4);
        beat(8'hAA); beat(8'hBB);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
        @(negedge clk);
        check("post_rst_data", out_data, 32'h04030201);
        check("post_rst_valid", 32'(out_valid), 32'd1);

`ifdef STREAM_UPSIZER_LAST_EN
        @(posedge clk); #1;
        beat(8'h10);
        tb_last = 1'b1;
        beat(8'h20);
        tb_last = 1'b0;
        @(negedge clk);
        check("last_data", out_data, 32'h00002010);
        check("last_keep", 32'(out_keep), 32'h3);
        check("last_flag", 32'(out_last), 32'd1);
`endif

        // Randomised valid/ready against a fifo consumer
        @(posedge clk); #1;
        n_words = word_cyc.size();
        fifo_cnt = 0; rand_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            beat(8'($urandom));
        end
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_word_count", 32'(word_cyc.size() - n_words), 32'd15);
        check("rand_partial_empty", 32'(m_cnt), 32'd0);
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 Parameter IN_WIDTH, default 8: width of one input beat in bits.
REQ-002 Parameter RATIO, default 4: number of input beats packed into one output word; legal values are 2 or more.
REQ-003 Derived width OUT_WIDTH = IN_WIDTH*RATIO; it SHALL NOT be overridable.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1: rising-edge clock for all state.
- rst_n  input  1: asynchronous active-low reset.
- in_data  input  IN_WIDTH: narrow input beat.
- in_valid  input  1: in_data is valid.
- in_ready  output  1: block accepts the beat this cycle.
- out_data  output  OUT_WIDTH: packed word, registered; intended to drive the fifo input.
- out_valid  output  1: out_data is valid.
- out_ready  input  1: downstream accepts the word this cycle.

Function
REQ-005 A beat transfers when in_valid && in_ready; a word transfers when out_valid && out_ready.
REQ-006 The i-th accepted beat of a word SHALL land in lane i, at bits [i*IN_WIDTH +: IN_WIDTH]; lane 0 is the LSB lane.
REQ-007 Beat counter cnt (width $clog2(RATIO)) increments on each beat transfer and wraps from RATIO-1 to 0.
REQ-008 Accumulation register holds lanes 0..RATIO-2; on the completing beat (cnt==RATIO-1) the full word SHALL be loaded into the output register.
REQ-009 Latency: out_valid SHALL rise on the cycle after the completing beat is accepted.
REQ-010 in_ready = !(cnt==RATIO-1 && out_valid && !out_ready); this is a combinational dependence on out_ready, and ready SHALL NOT depend on in_valid.
REQ-011 Throughput: with in_valid and out_ready held at 1, the block SHALL produce one word every RATIO cycles with no bubbles.
REQ-012 Simultaneous word transfer and completing-beat accept SHALL reload the output register in the same cycle, so out_valid stays 1.
REQ-013 A word transfer without a completing beat SHALL clear out_valid.
REQ-014 out_data SHALL hold stable while out_valid && !out_ready.
REQ-015 Lanes not written since the last word SHALL be emitted as 0 (accumulation lanes clear on word load).

Reset
REQ-016 Asserting rst_n low SHALL immediately, without a clock, set cnt=0, out_valid=0, out_data=0, accumulation=0, and out_last and out_keep to 0 when present.
REQ-017 Reset asserted mid-word SHALL discard the partial word; the first beat after release goes to lane 0.
REQ-018 in_ready SHALL be 1 during and after reset.

Configuration
REQ-019 Macro STREAM_UPSIZER_LAST_EN, when defined, SHALL add:
- in_last  input  1: marks the final beat of a packet.
- out_last  output  1: marks the final word of a packet.
- out_keep  output  RATIO: per-lane valid mask.
REQ-020 With STREAM_UPSIZER_LAST_EN, a beat with in_last=1 SHALL complete the word early:
- lanes 0..cnt are valid, higher lanes are 0;
- out_keep bit i = (i<=cnt);
- out_last=1;
- cnt returns to 0.
REQ-021 With STREAM_UPSIZER_LAST_EN, in_ready SHALL also deassert when in_last=1 would complete a word while the output register is held; the condition is (cnt==RATIO-1 || in_last) && out_valid && !out_ready.
REQ-022 Without the macro, none of in_last, out_last or out_keep exist, and every word is full.

Structure
REQ-023 Shared package stream_pkg SHALL hold the function upsizer_out_width(IN_WIDTH, RATIO) and the keep-mask function keep_mask(cnt, RATIO).
REQ-024 No sub-module SHALL be used; the output register is internal so that out_valid/out_data are registered and match the fifo's input handshake directly.
REQ-025 The block SHALL keep state in a packed self_t struct with comb next-state logic and a single always_ff.

Verification
REQ-026 Reset then beats 0x11,0x22,0x33,0x44 with out_ready=1 -> out_data=0x44332211 and out_valid high for 1 cycle, one cycle after the 4th beat.
REQ-027 Continuous in_valid for 16 beats with out_ready=1 -> 4 words on cycles 5,9,13,17 and in_ready never low.
REQ-028 Complete one word with out_ready=0, then present a 5th-8th beat stream -> beats 5-7 accepted, in_ready=0 on beat 8 until out_ready=1, both words intact.
REQ-029 rst_n pulsed low after 2 beats (0xAA,0xBB), then 0x01..0x04 -> out_data=0x04030201, and no 0xAA/0xBB in the output.
REQ-030 With STREAM_UPSIZER_LAST_EN: 0x10,0x20 with in_last on 0x20 -> out_data=0x00002010, out_keep=4'b0011, out_last=1.
REQ-031 Randomised valid/ready against a fifo DEPTH=4 consumer -> scoreboard shows lossless, in-order words.
